// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared widths, FSM state and command types for mem_arb2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              idx;
    } arb_cmd_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == C_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb2_if.sv
// ============================================================================
// Module      : mem_arb2_if
// Description : Requester and memory-port bundle for mem_arb2.
//               Stats counters present only with MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arb2_if;
    import mem_arb_pkg::*;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;
    logic              busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]       wr_cnt0;
    logic [15:0]       wr_cnt1;
    logic [15:0]       rd_cnt0;
    logic [15:0]       rd_cnt1;
`endif

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
        output gnt, rvalid, rdata, mem_addr, mem_data_in, mem_read, mem_write, busy
`ifdef MEM_ARB_STATS_EN
        , output wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1
`endif
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  gnt, rvalid, rdata, mem_addr, mem_data_in, mem_read, mem_write, busy
`ifdef MEM_ARB_STATS_EN
        , input wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1
`endif
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb2_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational round-robin pick; on a tie the port
//               that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic [1:0]      win_oh,
    output logic            win_idx
);

    assign win_idx = req[1] & (~req[0] | ~last);
    assign win_oh  = (req == 2'b00) ? 2'b00 : (win_idx ? 2'b10 : 2'b01);

endmodule

`default_nettype wire

// File: rtl/mem_arb2.sv
// ============================================================================
// Module      : mem_arb2
// Description : Round-robin two-port arbiter/sequencer for a 32x8 sync memory.
//               Optional per-port grant counters under MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb2
    import mem_arb_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    mem_arb2_if.slave   bus
);

    arb_state_t        r_state;
    arb_cmd_t          r_cmd;
    logic              r_last;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [1:0]        w_win_oh;
    logic              w_win_idx;
    arb_cmd_t          w_next_cmd;

    rr_arb2 u_rr (
        .req     (bus.req),
        .last    (r_last),
        .win_oh  (w_win_oh),
        .win_idx (w_win_idx)
    );

    always_comb begin
        w_next_cmd     = '0;
        w_next_cmd.idx = w_win_idx;
        if (w_win_idx) begin
            w_next_cmd.we    = bus.we[1];
            w_next_cmd.addr  = bus.addr1;
            w_next_cmd.wdata = bus.wdata1;
        end else begin
            w_next_cmd.we    = bus.we[0];
            w_next_cmd.addr  = bus.addr0;
            w_next_cmd.wdata = bus.wdata0;
        end
    end

    // Strobes and grant are loaded on entry to WR/RD so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_last        <= 1'b1;
            r_gnt         <= '0;
            r_rvalid      <= '0;
            r_rdata       <= '0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_cmd         <= w_next_cmd;
                        r_last        <= w_win_idx;
                        r_gnt         <= w_win_oh;
                        r_mem_addr    <= w_next_cmd.addr;
                        r_mem_data_in <= w_next_cmd.wdata;
                        r_mem_write   <= w_next_cmd.we;
                        r_mem_read    <= ~w_next_cmd.we;
                        r_state       <= w_next_cmd.we ? WR : RD;
                    end
                end
                WR: begin
                    r_gnt       <= '0;
                    r_mem_write <= 1'b0;
                    r_state     <= IDLE;
                end
                RD: begin
                    r_gnt      <= '0;
                    r_mem_read <= 1'b0;
                    r_state    <= CAP;
                end
                CAP: begin
                    r_rdata  <= bus.mem_data_out;
                    r_rvalid <= r_cmd.idx ? 2'b10 : 2'b01;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.rvalid      = r_rvalid;
    assign bus.rdata       = r_rdata;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.busy        = (r_state != IDLE);

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_wr_cnt0;
    logic [15:0] r_wr_cnt1;
    logic [15:0] r_rd_cnt0;
    logic [15:0] r_rd_cnt1;

    // r_cmd is stable while the grant pulse is high, so it tags the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt0 <= '0;
            r_wr_cnt1 <= '0;
            r_rd_cnt0 <= '0;
            r_rd_cnt1 <= '0;
        end else if (|r_gnt) begin
            case ({r_cmd.idx, r_cmd.we})
                2'b01:   r_wr_cnt0 <= sat_inc(r_wr_cnt0);
                2'b11:   r_wr_cnt1 <= sat_inc(r_wr_cnt1);
                2'b00:   r_rd_cnt0 <= sat_inc(r_rd_cnt0);
                default: r_rd_cnt1 <= sat_inc(r_rd_cnt1);
            endcase
        end
    end

    assign bus.wr_cnt0 = r_wr_cnt0;
    assign bus.wr_cnt1 = r_wr_cnt1;
    assign bus.rd_cnt0 = r_rd_cnt0;
    assign bus.rd_cnt1 = r_rd_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arb2.sv
// ============================================================================
// Module      : tb_mem_arb2
// Description : Directed self-checking bench for mem_arb2 with a 32x8 memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb2;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_arb2_if bus ();

    mem_arb2 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DATA_W-1:0] mem [0:31];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
        if (bus.mem_read)  bus.mem_data_out  <= mem[bus.mem_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input bit w, input logic [4:0] a, input logic [7:0] d);
        bus.req[p] = 1'b1;
        bus.we[p]  = w;
        if (p) begin
            bus.addr1  = a;
            bus.wdata1 = d;
        end else begin
            bus.addr0  = a;
            bus.wdata0 = d;
        end
    endtask

    task automatic wait_gnt(input bit p, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.gnt[p]) seen = 1'b1;
        end
        chk("gnt_seen", 32'(seen), 32'd1);
        chk("gnt_onehot", 32'(bus.gnt), p ? 32'd2 : 32'd1);
    endtask

    task automatic do_write(input bit p, input logic [4:0] a, input logic [7:0] d);
        int n;
        drive(p, 1'b1, a, d);
        wait_gnt(p, n);
        chk("wr_strobes", 32'({bus.mem_write, bus.mem_read}), 32'd2);
        chk("wr_addr", 32'(bus.mem_addr), 32'(a));
        chk("wr_data", 32'(bus.mem_data_in), 32'(d));
        bus.req = 2'b00;
        @(posedge clk); #1;
        chk("wr_back_idle", 32'({bus.busy, bus.mem_write}), 32'd0);
    endtask

    task automatic do_read(input bit p, input logic [4:0] a, input logic [7:0] d);
        int n;
        drive(p, 1'b0, a, 8'h00);
        wait_gnt(p, n);
        chk("rd_strobes", 32'({bus.mem_write, bus.mem_read}), 32'd1);
        chk("rd_addr", 32'(bus.mem_addr), 32'(a));
        bus.req = 2'b00;
        @(posedge clk); #1;
        chk("rd_cap_no_rvalid", 32'({bus.rvalid, bus.mem_read, bus.busy}), 32'd1);
        @(posedge clk); #1;
        chk("rd_rvalid", 32'(bus.rvalid), p ? 32'd2 : 32'd1);
        chk("rd_rdata", 32'(bus.rdata), 32'(d));
        chk("rd_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int g0, g1, rv, gcnt;
        bit exp_g, exp_rv, ov, rv_seen;
        logic [4:0] a;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req = 2'b00; bus.we = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt_rvalid", 32'({bus.gnt, bus.rvalid}), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_mem_port", 32'({bus.mem_addr, bus.mem_data_in, bus.mem_read, bus.mem_write}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Single write then read on port 0, including grant latency.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 5'h0A, 8'h5C);
        wait_gnt(1'b0, n);
        chk("t1_wr_latency", 32'(n), 32'd1);
        chk("t1_wr_strobe", 32'({bus.mem_write, bus.mem_read, bus.busy}), 32'b101);
        chk("t1_wr_addr_data", 32'({bus.mem_addr, bus.mem_data_in}), 32'({5'h0A, 8'h5C}));
        bus.req = 2'b00;
        @(posedge clk); #1;
        chk("t1_wr_done", 32'({bus.gnt, bus.mem_write, bus.busy}), 32'd0);
        do_read(1'b0, 5'h0A, 8'h5C);

        // Simultaneous writes after reset: port 0 first, port 1 two cycles later.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 5'd3, 8'h11);
        drive(1'b1, 1'b1, 5'd4, 8'h22);
        @(posedge clk); #1;
        chk("t2_first_gnt", 32'(bus.gnt), 32'd1);
        chk("t2_first_addr", 32'({bus.mem_addr, bus.mem_data_in}), 32'({5'd3, 8'h11}));
        bus.req[0] = 1'b0;
        @(posedge clk); #1;
        chk("t2_gap", 32'({bus.gnt, bus.busy}), 32'd0);
        @(posedge clk); #1;
        chk("t2_second_gnt", 32'(bus.gnt), 32'd2);
        chk("t2_second_addr", 32'({bus.mem_addr, bus.mem_data_in, bus.mem_write}), 32'({5'd4, 8'h22, 1'b1}));
        bus.req = 2'b00;
        @(posedge clk); #1;
        do_read(1'b0, 5'd3, 8'h11);
        do_read(1'b1, 5'd4, 8'h22);

        // Fairness: both ports keep reading; last grant was port 1.
        drive(1'b0, 1'b0, 5'd3, 8'h00);
        drive(1'b1, 1'b0, 5'd4, 8'h00);
        g0 = 0; g1 = 0; rv = 0; gcnt = 0;
        exp_g = 1'b0; exp_rv = 1'b0; ov = 1'b0;
        for (int c = 0; c < 200 && rv < 20; c++) begin
            @(posedge clk); #1;
            if (bus.mem_read && bus.mem_write) ov = 1'b1;
            if (bus.gnt != 2'b00) begin
                chk("t3_order", 32'(bus.gnt), exp_g ? 32'd2 : 32'd1);
                if (bus.gnt[0]) g0++;
                if (bus.gnt[1]) g1++;
                exp_g = ~exp_g;
                gcnt++;
                if (gcnt == 20) bus.req = 2'b00;
            end
            if (bus.rvalid != 2'b00) begin
                chk("t3_rvalid", 32'(bus.rvalid), exp_rv ? 32'd2 : 32'd1);
                chk("t3_rdata", 32'(bus.rdata), exp_rv ? 32'h22 : 32'h11);
                exp_rv = ~exp_rv;
                rv++;
            end
        end
        bus.req = 2'b00;
        chk("t3_gnt0_count", 32'(g0), 32'd10);
        chk("t3_gnt1_count", 32'(g1), 32'd10);
        chk("t3_rvalid_count", 32'(rv), 32'd20);
        chk("t3_no_overlap", 32'(ov), 32'd0);

        // Sweep: port 1 writes ~addr everywhere, port 0 reads it back.
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            do_write(1'b1, a, ~{3'b000, a});
        end
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            do_read(1'b0, a, ~{3'b000, a});
        end

        // Reset during RD: strobes drop at once, no rvalid follows.
        drive(1'b0, 1'b0, 5'h0A, 8'h00);
        wait_gnt(1'b0, n);
        chk("t5_in_rd", 32'(bus.mem_read), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_strobes_async", 32'({bus.mem_read, bus.mem_write, bus.gnt}), 32'd0);
        chk("t5_outputs_zero", 32'({bus.rvalid, bus.rdata, bus.mem_addr, bus.mem_data_in, bus.busy}), 32'd0);
        bus.req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        rv_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.rvalid != 2'b00) rv_seen = 1'b1;
        end
        chk("t5_no_rvalid", 32'(rv_seen), 32'd0);
        do_read(1'b0, 5'h0A, 8'hF5);

`ifdef MEM_ARB_STATS_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("st_reset", 32'(bus.wr_cnt0), 32'd0);
        do_write(1'b0, 5'd1, 8'hA1);
        do_write(1'b0, 5'd2, 8'hA2);
        do_write(1'b0, 5'd3, 8'hA3);
        do_read(1'b0, 5'd1, 8'hA1);
        do_read(1'b0, 5'd2, 8'hA2);
        do_read(1'b1, 5'd3, 8'hA3);
        chk("st_wr_cnt0", 32'(bus.wr_cnt0), 32'd3);
        chk("st_rd_cnt0", 32'(bus.rd_cnt0), 32'd2);
        chk("st_wr_cnt1", 32'(bus.wr_cnt1), 32'd0);
        chk("st_rd_cnt1", 32'(bus.rd_cnt1), 32'd1);
        force u_dut.r_wr_cnt0 = 16'hFFFF;
        @(posedge clk); #1;
        release u_dut.r_wr_cnt0;
        do_write(1'b0, 5'd4, 8'hA4);
        chk("st_saturate", 32'(bus.wr_cnt0), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
